// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: register id sentinel,
// access-size codes and MA state encoding.
package mem_access_stage_pkg;

  localparam logic [6:0] UREG_ZZR = 7'h7F;

  typedef enum logic [1:0] {
    MSZ_B   = 2'd0,
    MSZ_W   = 2'd1,
    MSZ_L   = 2'd2,
    MSZ_RSV = 2'd3
  } msz_e;

  typedef enum logic {
    MAST_IDLE = 1'b0,
    MAST_REQ  = 1'b1
  } mast_e;

  // A request is illegal when it is ambiguous, uses the reserved size, or is misaligned.
  function automatic logic is_illegal(input logic ld, input logic st,
                                      input logic [1:0] size, input logic [1:0] lo);
    return (ld & st) || (size == MSZ_RSV) ||
           ((size == MSZ_W) && lo[0]) ||
           ((size == MSZ_L) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ma_lane_align.sv
// Combinational lane logic: byte-enable generation, store replication and
// load byte/halfword extraction with sign or zero extension.
module ma_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic        ld_sx,
  input  logic [31:0] ld_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data_rep,
  output logic [31:0] ld_val
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_raw[{addr_lo, 3'b000} +: 8];
    ld_half = ld_raw[{addr_lo[1], 4'b0000} +: 16];

    byte_en     = 4'b0000;
    st_data_rep = 32'h0;
    ld_val      = 32'h0;
    case (size)
      MSZ_B: begin
        byte_en     = 4'b0001 << addr_lo;
        st_data_rep = {4{st_data[7:0]}};
        ld_val      = {{24{ld_sx & ld_byte[7]}}, ld_byte};
      end
      MSZ_W: begin
        byte_en     = 4'b0011 << addr_lo;
        st_data_rep = {2{st_data[15:0]}};
        ld_val      = {{16{ld_sx & ld_half[15]}}, ld_half};
      end
      MSZ_L: begin
        byte_en     = 4'b1111;
        st_data_rep = st_data;
        ld_val      = ld_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX load/store requests into one handshaked bus
// transaction each, stalls the pipe meanwhile, and registers writeback/fault.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic        memLoad,
  input  logic        memStore,
  input  logic [1:0]  memSize,
  input  logic        memLdSx,
  input  logic [6:0]  memLdId,
  output logic        memHold,
  output logic [6:0]  regOutId,
  output logic [31:0] regOutVal,
  output logic        memFault,
  output logic [31:0] busAddr,
  output logic [31:0] busDataOut,
  input  logic [31:0] busDataIn,
  output logic [3:0]  busByteEn,
  output logic        busOE,
  output logic        busWE,
  input  logic        busOK
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  mast_e       state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        sx_q, sx_d;
  logic        load_q, load_d;
  logic [6:0]  ld_id_q, ld_id_d;
  logic [6:0]  reg_id_q, reg_id_d;
  logic [31:0] reg_val_q, reg_val_d;
  logic        fault_q, fault_d;

  logic        in_req;
  logic [3:0]  lane_be;
  logic [31:0] lane_st;
  logic [31:0] lane_ld;

  ma_lane_align u_lane (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .st_data     (data_q),
    .ld_sx       (sx_q),
    .ld_raw      (busDataIn),
    .byte_en     (lane_be),
    .st_data_rep (lane_st),
    .ld_val      (lane_ld)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    sx_d      = sx_q;
    load_d    = load_q;
    ld_id_d   = ld_id_q;
    reg_id_d  = UREG_ZZR;
    reg_val_d = 32'h0;
    fault_d   = 1'b0;

    case (state_q)
      MAST_IDLE: begin
        if (memLoad | memStore) begin
          if (is_illegal(memLoad, memStore, memSize, memAddr[1:0])) begin
            fault_d = 1'b1;
          end else begin
            addr_d  = memAddr;
            data_d  = memData;
            size_d  = memSize;
            sx_d    = memLdSx;
            load_d  = memLoad;
            ld_id_d = memLdId;
            cnt_d   = 8'd0;
            state_d = MAST_REQ;
          end
        end
      end
      MAST_REQ: begin
        // busOK takes priority over an expiring timeout on the same edge.
        if (busOK) begin
          state_d = MAST_IDLE;
          if (load_q) begin
            reg_id_d  = ld_id_q;
            reg_val_d = lane_ld;
          end
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          fault_d = 1'b1;
          state_d = MAST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = MAST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= MAST_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      size_q    <= 2'd0;
      sx_q      <= 1'b0;
      load_q    <= 1'b0;
      ld_id_q   <= 7'd0;
      reg_id_q  <= UREG_ZZR;
      reg_val_q <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      size_q    <= size_d;
      sx_q      <= sx_d;
      load_q    <= load_d;
      ld_id_q   <= ld_id_d;
      reg_id_q  <= reg_id_d;
      reg_val_q <= reg_val_d;
      fault_q   <= fault_d;
    end
  end

  // Bus outputs are gated by state so the bus is quiet whenever IDLE.
  assign in_req     = (state_q == MAST_REQ);
  assign memHold    = in_req;
  assign busOE      = in_req & load_q;
  assign busWE      = in_req & ~load_q;
  assign busAddr    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign busByteEn  = in_req ? lane_be : 4'b0000;
  assign busDataOut = (in_req & ~load_q) ? lane_st : 32'h0;
  assign regOutId   = reg_id_q;
  assign regOutVal  = reg_val_q;
  assign memFault   = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level model of lanes, extension and handshake timing.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] memAddr, memData;
  logic        memLoad, memStore;
  logic [1:0]  memSize;
  logic        memLdSx;
  logic [6:0]  memLdId;
  logic        memHold;
  logic [6:0]  regOutId;
  logic [31:0] regOutVal;
  logic        memFault;
  logic [31:0] busAddr, busDataOut, busDataIn;
  logic [3:0]  busByteEn;
  logic        busOE, busWE, busOK;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_wb_val;

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .memAddr(memAddr), .memData(memData), .memLoad(memLoad), .memStore(memStore),
    .memSize(memSize), .memLdSx(memLdSx), .memLdId(memLdId),
    .memHold(memHold), .regOutId(regOutId), .regOutVal(regOutVal), .memFault(memFault),
    .busAddr(busAddr), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .busByteEn(busByteEn), .busOE(busOE), .busWE(busWE), .busOK(busOK)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] din, input int lo,
                                             input logic [1:0] sz, input logic sx);
    logic [31:0] v, mask;
    logic        sign;
    if (sz == 2'd2) return din;
    v    = din >> (lo * 8);
    mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    sign = (sz == 2'd0) ? v[7] : v[15];
    v    = v & mask;
    if (sx && sign) v = v | ~mask;
    return v;
  endfunction

  // ok_at: REQ cycle (1-based) in which busOK is high; 0 or >TMO means never.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d,
                           input logic ld, input logic st, input logic [1:0] sz,
                           input logic sx, input logic [6:0] id, input int ok_at,
                           input bit force_din, input logic [31:0] din_val);
    logic        ill;
    logic [31:0] din, exp_do;
    logic [3:0]  exp_be;
    int          lo;
    lo     = int'(a[1:0]);
    ill    = (ld && st) || sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_be = (sz == 2'd0) ? 4'(1 << lo) : (sz == 2'd1) ? 4'(3 << lo) : 4'hF;
    exp_do = (sz == 2'd0) ? {24'b0, d[7:0]} * 32'h0101_0101 :
             (sz == 2'd1) ? {16'b0, d[15:0]} * 32'h0001_0001 : d;
    din    = 32'h0;

    @(negedge clock);
    chk("idle_hold", memHold, 0);
    chk("idle_wb_id", regOutId, UREG_ZZR);
    chk("idle_fault", memFault, 0);
    memAddr = a; memData = d; memLoad = ld; memStore = st;
    memSize = sz; memLdSx = sx; memLdId = id;
    busOK = 1'($urandom % 2);
    @(negedge clock);
    memLoad = 1'b0; memStore = 1'b0; memAddr = $urandom; memData = $urandom; busOK = 1'b0;
    if (ill) begin
      chk("ill_fault", memFault, 1);
      chk("ill_oe", busOE, 0);
      chk("ill_we", busWE, 0);
      chk("ill_hold", memHold, 0);
      return;
    end
    for (int n = 1; n <= TMO; n++) begin
      chk("req_hold", memHold, 1);
      chk("req_oe", busOE, ld);
      chk("req_we", busWE, st);
      chk("req_addr", busAddr, {a[31:2], 2'b00});
      chk("req_be", busByteEn, exp_be);
      if (st) chk("req_dout", busDataOut, exp_do);
      chk("req_fault", memFault, 0);
      busDataIn = force_din ? din_val : $urandom;
      if (n == ok_at) begin
        busOK = 1'b1;
        din   = busDataIn;
      end
      @(negedge clock);
      busOK = 1'b0;
      if (n == ok_at) break;
    end
    chk("done_hold", memHold, 0);
    chk("done_oe", busOE, 0);
    chk("done_we", busWE, 0);
    last_wb_val = regOutVal;
    if (ok_at >= 1 && ok_at <= TMO) begin
      chk("done_fault", memFault, 0);
      chk("wb_id", regOutId, ld ? id : UREG_ZZR);
      chk("wb_val", regOutVal, ld ? model_load(din, lo, sz, sx) : 32'h0);
    end else begin
      chk("tmo_fault", memFault, 1);
      chk("tmo_wb_id", regOutId, UREG_ZZR);
      chk("tmo_wb_val", regOutVal, 0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rsz;
    int          r;
    reset = 1'b1; memAddr = 0; memData = 0; memLoad = 0; memStore = 0;
    memSize = 0; memLdSx = 0; memLdId = 0; busDataIn = 0; busOK = 0;
    repeat (2) @(negedge clock);
    chk("rst_oe", busOE, 0);
    chk("rst_we", busWE, 0);
    chk("rst_hold", memHold, 0);
    chk("rst_fault", memFault, 0);
    chk("rst_wb_id", regOutId, UREG_ZZR);
    chk("rst_wb_val", regOutVal, 0);
    chk("rst_be", busByteEn, 0);
    reset = 1'b0;

    do_access(32'h1003, 32'h0, 1, 0, 2'd0, 1, 7'd5, 2, 1, 32'h8000_0000);
    chk("sbyte_val", last_wb_val, 32'hFFFF_FF80);
    do_access(32'h1003, 32'h0, 1, 0, 2'd0, 0, 7'd5, 2, 1, 32'h8000_0000);
    chk("ubyte_val", last_wb_val, 32'h0000_0080);
    do_access(32'h2002, 32'h1234_ABCD, 0, 1, 2'd1, 0, 7'd0, 1, 0, 32'h0);
    do_access(32'h3001, 32'h0, 1, 0, 2'd2, 0, 7'd9, 1, 0, 32'h0);
    do_access(32'h4000, 32'h0, 1, 1, 2'd2, 0, 7'd9, 1, 0, 32'h0);
    do_access(32'h5000, 32'h0, 1, 0, 2'd2, 0, 7'd3, 0, 0, 32'h0);
    do_access(32'h5004, 32'h0, 1, 0, 2'd2, 0, 7'd4, TMO, 0, 32'h0);

    // Reset in the third REQ cycle of a load.
    @(negedge clock);
    memAddr = 32'h6000; memLoad = 1'b1; memSize = 2'd2; memLdId = 7'd7;
    @(negedge clock);
    memLoad = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rreq_hold", memHold, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rreq_oe", busOE, 0);
    chk("rreq_hold2", memHold, 0);
    chk("rreq_wb_id", regOutId, UREG_ZZR);
    chk("rreq_fault", memFault, 0);
    do_access(32'h6000, 32'h0, 1, 0, 2'd2, 0, 7'd7, 1, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rsz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      if ($urandom % 4 != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      r = $urandom_range(0, 15);
      do_access(ra, $urandom, (r == 0) || r[0], (r == 0) || !r[0], rsz,
                1'($urandom % 2), 7'($urandom_range(0, 126)),
                $urandom_range(0, 9), 0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
